// File: rtl/hazard_pkg.sv
// Shared constants for the hazard controller with MDU scoreboard.
// Build option: HAZARD_PERF_CNT_EN adds stall/flush performance counters.
package hazard_pkg;

  localparam int REG_W_DEF = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // The M stage holds the younger result, so it beats W.
  function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
    if (m_hit)      return FWD_M;
    else if (w_hit) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sb_if.sv
// Pipeline-side signal bundle of the hazard controller.
// Build option: HAZARD_PERF_CNT_EN adds PERF_W and the two counter outputs.
interface hazard_ctrl_sb_if #(
  parameter int REG_W = hazard_pkg::REG_W_DEF
`ifdef HAZARD_PERF_CNT_EN
  , parameter int PERF_W = 32
`endif
);
  logic [REG_W-1:0] Rs1D, Rs2D, RdD;
  logic             RegWriteD, MduOpD;
  logic [REG_W-1:0] Rs1E, Rs2E, RdE;
  logic             ResultSrcb0E, MduStartE, PCSrcE;
  logic [REG_W-1:0] RdM, RdW;
  logic             RegWriteM, RegWriteW;
  // MemReqM/MemReadyM: a request in M completes in the cycle both are high;
  // while MemReqM is high and MemReadyM low the whole pipeline waits.
  logic             MemReqM, MemReadyM;
  logic             MduDone;
  logic [REG_W-1:0] MduRd;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MduBusy;
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] PerfStallCnt, PerfFlushCnt;
`endif

  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, MduOpD, Rs1E, Rs2E, RdE,
           ResultSrcb0E, MduStartE, PCSrcE, RdM, RdW, RegWriteM, RegWriteW,
           MemReqM, MemReadyM, MduDone, MduRd,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MduBusy
`ifdef HAZARD_PERF_CNT_EN
    , input PerfStallCnt, PerfFlushCnt
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, MduOpD, Rs1E, Rs2E, RdE,
           ResultSrcb0E, MduStartE, PCSrcE, RdM, RdW, RegWriteM, RegWriteW,
           MemReqM, MemReadyM, MduDone, MduRd,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MduBusy
`ifdef HAZARD_PERF_CNT_EN
    , output PerfStallCnt, PerfFlushCnt
`endif
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Pending-write bit per register plus a busy flag for the single
// outstanding MDU operation. x0 is never marked pending.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int NREGS = 2**REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  output logic             rs1_pend,
  output logic             rs2_pend,
  output logic             rd_pend,
  output logic             busy
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic             busy_q, busy_d;

  // Clear is applied first so a same-cycle set on the same register wins;
  // a completion with nothing outstanding is dropped.
  always_comb begin
    pending_d = pending_q;
    busy_d    = busy_q;
    if (clr_en && busy_q) begin
      pending_d[clr_rd] = 1'b0;
      busy_d            = 1'b0;
    end
    if (set_en) begin
      if (set_rd != '0) pending_d[set_rd] = 1'b1;
      busy_d = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  assign rs1_pend = pending_q[rs1];
  assign rs2_pend = pending_q[rs2];
  assign rd_pend  = pending_q[rd];
  assign busy     = busy_q;

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Five-stage hazard controller: forwarding, load-use, MDU scoreboard,
// memory wait states and branch flushes. Build option: HAZARD_PERF_CNT_EN.
module hazard_ctrl_sb
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int NREGS = 2**REG_W
`ifdef HAZARD_PERF_CNT_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  hazard_ctrl_sb_if.slave    hif
);

  logic rs1_pend, rs2_pend, rd_pend, mdu_busy;
  logic lw_stall, sb_stall, mem_stall;
  logic stall_e, sb_set;

  assign mem_stall = hif.MemReqM & ~hif.MemReadyM;
  assign stall_e   = mem_stall;
  assign sb_set    = hif.MduStartE & ~stall_e;

  hazard_scoreboard #(.REG_W(REG_W), .NREGS(NREGS)) u_sb (
    .clk      (clk),
    .rst      (reset),
    .set_en   (sb_set),
    .set_rd   (hif.RdE),
    .clr_en   (hif.MduDone),
    .clr_rd   (hif.MduRd),
    .rs1      (hif.Rs1D),
    .rs2      (hif.Rs2D),
    .rd       (hif.RdD),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend),
    .busy     (mdu_busy)
  );

  assign lw_stall = hif.ResultSrcb0E & ((hif.Rs1D == hif.RdE) | (hif.Rs2D == hif.RdE));

  // A launching MDU op in E counts as busy so D cannot issue a second one.
  assign sb_stall = rs1_pend | rs2_pend | (hif.RegWriteD & rd_pend)
                  | (hif.MduOpD & (mdu_busy | hif.MduStartE));

  assign hif.ForwardAE = fwd_sel((hif.Rs1E != '0) && hif.RegWriteM && (hif.Rs1E == hif.RdM),
                                 (hif.Rs1E != '0) && hif.RegWriteW && (hif.Rs1E == hif.RdW));
  assign hif.ForwardBE = fwd_sel((hif.Rs2E != '0) && hif.RegWriteM && (hif.Rs2E == hif.RdM),
                                 (hif.Rs2E != '0) && hif.RegWriteW && (hif.Rs2E == hif.RdW));

  assign hif.StallF  = lw_stall | sb_stall | mem_stall;
  assign hif.StallD  = lw_stall | sb_stall | mem_stall;
  assign hif.StallE  = stall_e;
  assign hif.StallM  = mem_stall;
  assign hif.FlushW  = mem_stall;
  // A frozen branch re-resolves once memory is ready, so holding off is safe.
  assign hif.FlushE  = ~mem_stall & (lw_stall | sb_stall | hif.PCSrcE);
  assign hif.FlushD  = ~mem_stall & hif.PCSrcE;
  assign hif.MduBusy = mdu_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hif.StallF && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    if ((hif.FlushD || hif.FlushE) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hif.PerfStallCnt = stall_cnt_q;
  assign hif.PerfFlushCnt = flush_cnt_q;
`endif

endmodule
